// File: rtl/date_seg_pkg.sv
// Shared constants and helpers for the BCD date counter and its 7-segment display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package date_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS_WAIT,
        DB_HELD,
        DB_RELEASE_WAIT
    } deb_state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Two-digit years 2000-2099: divisible by 4 reduces to a tens-parity/units test.
    function automatic logic is_leap(input logic [7:0] year_bcd);
        logic [3:0] units;
        units = year_bcd[3:0];
        if (!year_bcd[4])
            return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
        else
            return (units == 4'd2) || (units == 4'd6);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] month_bcd,
                                                 input logic [7:0] year_bcd);
        logic [7:0] dim;
        case (month_bcd)
            8'h02:                      dim = is_leap(year_bcd) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
            default:                    dim = 8'h31;
        endcase
        return dim;
    endfunction

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val);
        logic [7:0] res;
        if (val[3:0] == 4'd9) begin
            res[3:0] = 4'd0;
            res[7:4] = (val[7:4] == 4'd9) ? 4'd0 : val[7:4] + 4'd1;
        end else begin
            res[3:0] = val[3:0] + 4'd1;
            res[7:4] = val[7:4];
        end
        return res;
    endfunction

endpackage

// File: rtl/date_seg_counter_debounce.sv
// Push-button conditioner: 2-FF synchronizer plus press/release debounce FSM
// producing a single-cycle pulse per accepted press.
module btn_debounce
    import date_seg_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync_1;
    logic             btn_s;
    logic [1:0]       sync_valid;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             pulse_set;
    deb_state_t       state;
    deb_state_t       state_next;

    assign cnt_done = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1     <= 1'b1;
            btn_s      <= 1'b1;
            sync_valid <= '0;
        end else begin
            sync_1     <= btn;
            btn_s      <= sync_1;
            sync_valid <= {sync_valid[0], 1'b1};
        end
    end

    // The synchronizer is preset to "released", so a button held through reset would
    // look like a fresh press; presses are ignored until a real release reaches btn_s.
    always_ff @(posedge clk) begin
        if (rst)
            armed <= 1'b0;
        else if (sync_valid[1] && btn_s)
            armed <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DB_IDLE;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            state       <= state_next;
            press_pulse <= pulse_set;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DB_IDLE:
                if (!btn_s && armed)
                    state_next = DB_PRESS_WAIT;
            DB_PRESS_WAIT:
                if (btn_s)
                    state_next = DB_IDLE;
                else if (cnt_done)
                    state_next = DB_HELD;
            DB_HELD:
                if (btn_s)
                    state_next = DB_RELEASE_WAIT;
            DB_RELEASE_WAIT:
                if (!btn_s)
                    state_next = DB_HELD;
                else if (cnt_done)
                    state_next = DB_IDLE;
            default:
                state_next = DB_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr   = (state == DB_IDLE) || (state == DB_HELD);
        cnt_inc   = !cnt_done &&
                    (((state == DB_PRESS_WAIT) && !btn_s) ||
                     ((state == DB_RELEASE_WAIT) && btn_s));
        pulse_set = (state == DB_PRESS_WAIT) && !btn_s && cnt_done;
    end

endmodule

// File: rtl/date_seg_counter.sv
// Six-digit YY-MM-DD calendar advanced one day per debounced button press,
// shown on six registered active-low 7-segment buses.
module date_seg_counter
    import date_seg_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [7:0]  RESET_YEAR      = 8'h24,
    parameter logic [7:0]  RESET_MONTH     = 8'h02,
    parameter logic [7:0]  RESET_DAY       = 8'h28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    output logic [6:0]  year_1,
    output logic [6:0]  year_2,
    output logic [6:0]  month_1,
    output logic [6:0]  month_2,
    output logic [6:0]  day_1,
    output logic [6:0]  day_2,
    output logic [23:0] date_bcd,
    output logic        adv_pulse
);

    logic [7:0] year;
    logic [7:0] month;
    logic [7:0] day;
    logic [7:0] year_next;
    logic [7:0] month_next;
    logic [7:0] day_next;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .press_pulse(adv_pulse)
    );

    always_comb begin
        year_next  = year;
        month_next = month;
        day_next   = bcd_inc(day);
        if (day == days_in_month(month, year)) begin
            day_next = 8'h01;
            if (month == 8'h12) begin
                month_next = 8'h01;
                year_next  = bcd_inc(year);
            end else begin
                month_next = bcd_inc(month);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            year  <= RESET_YEAR;
            month <= RESET_MONTH;
            day   <= RESET_DAY;
        end else if (adv_pulse) begin
            year  <= year_next;
            month <= month_next;
            day   <= day_next;
        end
    end

    assign date_bcd = {year, month, day};

    always_ff @(posedge clk) begin
        if (rst) begin
            year_1  <= bcd_to_seg(RESET_YEAR[7:4]);
            year_2  <= bcd_to_seg(RESET_YEAR[3:0]);
            month_1 <= bcd_to_seg(RESET_MONTH[7:4]);
            month_2 <= bcd_to_seg(RESET_MONTH[3:0]);
            day_1   <= bcd_to_seg(RESET_DAY[7:4]);
            day_2   <= bcd_to_seg(RESET_DAY[3:0]);
        end else begin
            year_1  <= bcd_to_seg(year[7:4]);
            year_2  <= bcd_to_seg(year[3:0]);
            month_1 <= bcd_to_seg(month[7:4]);
            month_2 <= bcd_to_seg(month[3:0]);
            day_1   <= bcd_to_seg(day[7:4]);
            day_2   <= bcd_to_seg(day[3:0]);
        end
    end

endmodule

// File: tb/tb_date_seg_counter.sv
// Directed bench for date_seg_counter: four instances with different reset dates,
// a press-count table on the default instance, and hand-written debounce/reset sequences.
module tb_date_seg_counter;

    localparam int unsigned DB = 4;
    localparam logic [23:0] RST_DATE [4] = '{24'h240228, 24'h230228, 24'h000228, 24'h991231};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn = 1'b1;
    logic        btn_x = 1'b1;

    logic [6:0]  y1 [4];
    logic [6:0]  y2 [4];
    logic [6:0]  m1 [4];
    logic [6:0]  m2 [4];
    logic [6:0]  d1 [4];
    logic [6:0]  d2 [4];
    logic [23:0] date [4];
    logic        adv [4];

    int total = 0;
    int bad = 0;
    int adv_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        date_seg_counter #(
            .DEBOUNCE_CYCLES(DB),
            .RESET_YEAR     (RST_DATE[g][23:16]),
            .RESET_MONTH    (RST_DATE[g][15:8]),
            .RESET_DAY      (RST_DATE[g][7:0])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .btn      ((g == 0) ? btn : btn_x),
            .year_1   (y1[g]),
            .year_2   (y2[g]),
            .month_1  (m1[g]),
            .month_2  (m2[g]),
            .day_1    (d1[g]),
            .day_2    (d2[g]),
            .date_bcd (date[g]),
            .adv_pulse(adv[g])
        );
    end

    always @(negedge clk) if (adv[0]) adv_cnt++;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [41:0] segs_of(input logic [23:0] d);
        return {seg(d[23:20]), seg(d[19:16]), seg(d[15:12]),
                seg(d[11:8]), seg(d[7:4]), seg(d[3:0])};
    endfunction

    function automatic logic [41:0] dut_segs(input int i);
        return {y1[i], y2[i], m1[i], m2[i], d1[i], d2[i]};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge.
    task automatic press(input int unsigned hold, input int unsigned rel);
        btn = 1'b0;
        repeat (hold) @(negedge clk);
        btn = 1'b1;
        repeat (rel) @(negedge clk);
    endtask

    typedef struct {
        int unsigned presses;
        logic [23:0] exp_date;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat_adv;
        int lat_date;
        int lat_seg;
        int snap;
        int waited;

        vecs[0] = '{1,  24'h240301};
        vecs[1] = '{30, 24'h240331};
        vecs[2] = '{1,  24'h240401};
        vecs[3] = '{8,  24'h240409};
        vecs[4] = '{1,  24'h240410};
        vecs[5] = '{20, 24'h240430};
        vecs[6] = '{1,  24'h240501};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_date", 64'(date[0]), 64'h240228);
        check("rst_segs", 64'(dut_segs(0)), 64'({7'h24, 7'h19, 7'h40, 7'h24, 7'h24, 7'h00}));
        check("rst_adv", 64'(adv[0]), 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Other reset dates: non-leap Feb, leap year 00, year wrap
        btn_x = 1'b0;
        repeat (12) @(negedge clk);
        btn_x = 1'b1;
        repeat (12) @(negedge clk);
        check("nonleap_feb", 64'(date[1]), 64'h230301);
        check("leap_00", 64'(date[2]), 64'h000229);
        check("year_wrap", 64'(date[3]), 64'h000101);
        check("year_wrap_segs", 64'(dut_segs(3)),
              64'({7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h79}));

        // Latency of first press on default instance, counted from the first sync edge
        lat_adv = 99; lat_date = 99; lat_seg = 99;
        snap = adv_cnt;
        btn = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (adv[0] && lat_adv == 99) lat_adv = k - 1;
            if (date[0] != 24'h240228 && lat_date == 99) lat_date = k - 1;
            if (d2[0] != 7'h00 && lat_seg == 99) lat_seg = k - 1;
        end
        @(negedge clk);
        repeat (6) @(negedge clk);
        btn = 1'b1;
        repeat (12) @(negedge clk);
        check("lat_adv", 64'(lat_adv), 64'd6);
        check("lat_date", 64'(lat_date), 64'd7);
        check("lat_seg", 64'(lat_seg), 64'd8);
        check("press1_count", 64'(adv_cnt - snap), 64'd1);
        check("press1_date", 64'(date[0]), 64'h240229);

        // Press-count table
        foreach (vecs[i]) begin
            snap = adv_cnt;
            for (int unsigned p = 0; p < vecs[i].presses; p++) press(12, 12);
            check($sformatf("vec%0d_date", i), 64'(date[0]), 64'(vecs[i].exp_date));
            check($sformatf("vec%0d_segs", i), 64'(dut_segs(0)), 64'(segs_of(vecs[i].exp_date)));
            check($sformatf("vec%0d_count", i), 64'(adv_cnt - snap), 64'(vecs[i].presses));
        end

        // Bouncy press: only the final stable low run is accepted
        snap = adv_cnt;
        for (int h = 0; h < 15; h++) begin
            btn = (h % 2 == 1);
            repeat (2) @(negedge clk);
        end
        btn = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_press", 64'(adv_cnt - snap), 64'd1);
        check("bounce_date", 64'(date[0]), 64'h240502);
        // Bouncy release then stable high
        for (int h = 0; h < 15; h++) begin
            btn = (h % 2 == 0);
            repeat (2) @(negedge clk);
        end
        btn = 1'b1;
        repeat (20) @(negedge clk);
        check("bounce_release", 64'(adv_cnt - snap), 64'd1);
        // Long hold never repeats
        press(1000, 20);
        check("long_hold", 64'(adv_cnt - snap), 64'd2);
        check("long_hold_date", 64'(date[0]), 64'h240503);

        // Reset while HELD with button still down
        btn = 1'b0;
        waited = 0;
        while (!adv[0] && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check("held_reach", 64'(adv[0]), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        snap = adv_cnt;
        repeat (30) @(negedge clk);
        check("held_rst_noadv", 64'(adv_cnt - snap), 64'd0);
        check("held_rst_date", 64'(date[0]), 64'h240228);
        check("held_rst_segs", 64'(dut_segs(0)), 64'(segs_of(24'h240228)));
        btn = 1'b1;
        repeat (20) @(negedge clk);
        press(12, 12);
        check("after_rst_count", 64'(adv_cnt - snap), 64'd1);
        check("after_rst_date", 64'(date[0]), 64'h240229);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
